// File: rtl/mips_bus_arbiter.sv
// Two-master (data port m0, instruction fetch m1) to one-slave bus arbiter for a MIPS core.
// Optional macro MIPS_BUS_ARBITER_ROUND_ROBIN_EN enables round-robin tie-breaking; otherwise m0 has fixed priority.
module mips_bus_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                s_read,
   output logic                s_write,
   output logic [ADDR_W-1:0]   s_address,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   output logic                protocol_error
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t state_q;
   logic   perr_q;
   logic   req0, req1, pick1;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

`ifdef MIPS_BUS_ARBITER_ROUND_ROBIN_EN
   // last_q = 1 means master 1 held the most recent grant, so master 0 wins the next tie.
   logic last_q;
   assign pick1 = req1 & (~req0 | ~last_q);
`else
   assign pick1 = req1 & ~req0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         perr_q  <= 1'b0;
`ifdef MIPS_BUS_ARBITER_ROUND_ROBIN_EN
         last_q  <= 1'b1;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 | req1) begin
                  state_q <= pick1 ? GRANT1 : GRANT0;
`ifdef MIPS_BUS_ARBITER_ROUND_ROBIN_EN
                  last_q  <= pick1;
`endif
               end
            end
            GRANT0: begin
               if (m0_read & m0_write) perr_q <= 1'b1;
               // Leave on completion or when the master abandons its request.
               if (!req0 || !s_waitrequest) state_q <= IDLE;
            end
            GRANT1: begin
               if (m1_read & m1_write) perr_q <= 1'b1;
               if (!req1 || !s_waitrequest) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Slave-side mux follows the granted master combinationally; a write wins a read+write collision.
   always_comb begin
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_address      = '0;
      s_writedata    = '0;
      s_byteenable   = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      case (state_q)
         GRANT0: begin
            s_read         = m0_read & ~m0_write;
            s_write        = m0_write;
            s_address      = m0_address;
            s_writedata    = m0_writedata;
            s_byteenable   = m0_byteenable;
            m0_waitrequest = s_waitrequest;
         end
         GRANT1: begin
            s_read         = m1_read & ~m1_write;
            s_write        = m1_write;
            s_address      = m1_address;
            s_writedata    = m1_writedata;
            s_byteenable   = m1_byteenable;
            m1_waitrequest = s_waitrequest;
         end
         default: ;
      endcase
   end

   assign m0_readdata    = s_readdata;
   assign m1_readdata    = s_readdata;
   assign protocol_error = perr_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter: reset, single read, stalled write,
// back-to-back contention, mid-transfer reset and read/write collision.
module tb_mips_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        m0_read = 0, m0_write = 0;
   logic [31:0] m0_address = 0, m0_writedata = 0;
   logic [3:0]  m0_byteenable = 0;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m1_read = 0, m1_write = 0;
   logic [31:0] m1_address = 0, m1_writedata = 0;
   logic [3:0]  m1_byteenable = 0;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        s_read, s_write;
   logic [31:0] s_address, s_writedata;
   logic [3:0]  s_byteenable;
   logic        s_waitrequest = 0;
   logic [31:0] s_readdata = 0;
   logic        protocol_error;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mips_bus_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .s_read(s_read), .s_write(s_write), .s_address(s_address),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .protocol_error(protocol_error)
   );

   task automatic test_reset();
      s_readdata = 32'h1234_5678;
      #3;
      checks++;
      if ({s_read, s_write, m0_waitrequest, m1_waitrequest, protocol_error} !== 5'b00110) begin
         errors++;
         $display("FAIL reset_held got=%b exp=00110", {s_read, s_write, m0_waitrequest, m1_waitrequest, protocol_error});
      end
      @(negedge clk) reset = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({s_read, s_write, m0_waitrequest, m1_waitrequest, protocol_error} !== 5'b00110) begin
         errors++;
         $display("FAIL reset_idle10 got=%b exp=00110", {s_read, s_write, m0_waitrequest, m1_waitrequest, protocol_error});
      end
      checks++;
      if (s_address !== 32'h0 || s_writedata !== 32'h0 || s_byteenable !== 4'h0) begin
         errors++;
         $display("FAIL reset_sbus got=%h/%h/%h exp=0/0/0", s_address, s_writedata, s_byteenable);
      end
      checks++;
      if (m0_readdata !== 32'h1234_5678 || m1_readdata !== 32'h1234_5678) begin
         errors++;
         $display("FAIL readdata_bcast got=%h/%h exp=12345678", m0_readdata, m1_readdata);
      end
      $display("reset: released, 10 idle cycles");
   endtask

   task automatic test_read_m1();
      @(posedge clk); #1;
      m1_read = 1; m1_address = 32'hBFC0_0000; s_waitrequest = 0; s_readdata = 32'h2402_0005;
      @(negedge clk);
      checks++;
      if (s_read !== 1'b0 || m1_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL rd_cycle1 got=s_read %b wr %b exp=0 1", s_read, m1_waitrequest);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (s_read !== 1'b1 || s_write !== 1'b0 || s_address !== 32'hBFC0_0000) begin
         errors++;
         $display("FAIL rd_cycle2_bus got=%b%b %h exp=10 bfc00000", s_read, s_write, s_address);
      end
      checks++;
      if (m1_waitrequest !== 1'b0 || m1_readdata !== 32'h2402_0005 || m0_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL rd_cycle2_m1 got=wr %b rd %h m0wr %b exp=0 24020005 1", m1_waitrequest, m1_readdata, m0_waitrequest);
      end
      @(posedge clk); #1;
      m1_read = 0;
      @(negedge clk);
      checks++;
      if (s_read !== 1'b0 || m1_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL rd_cycle3_idle got=%b %b exp=0 1", s_read, m1_waitrequest);
      end
      $display("read_m1: addr=bfc00000 data=%h", m1_readdata);
   endtask

   task automatic test_write_stall();
      int comp = 0;
      @(posedge clk); #1;
      m0_write = 1; m0_address = 32'h0000_1000; m0_writedata = 32'hDEAD_BEEF;
      m0_byteenable = 4'hF; s_waitrequest = 1;
      @(negedge clk);
      checks++;
      if (s_write !== 1'b0 || m0_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL wr_arb_cycle got=%b %b exp=0 1", s_write, m0_waitrequest);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i == 3) s_waitrequest = 0;
         @(negedge clk);
         checks++;
         if (s_write !== 1'b1 || s_read !== 1'b0 || s_address !== 32'h1000 ||
             s_writedata !== 32'hDEAD_BEEF || s_byteenable !== 4'hF) begin
            errors++;
            $display("FAIL wr_hold[%0d] got=%b%b %h %h %h exp=01 00001000 deadbeef f", i, s_read, s_write, s_address, s_writedata, s_byteenable);
         end
         checks++;
         if (m0_waitrequest !== (i < 3) || m1_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL wr_wait[%0d] got=%b %b exp=%b 1", i, m0_waitrequest, m1_waitrequest, (i < 3));
         end
         if (m0_write && !m0_waitrequest) comp++;
      end
      @(posedge clk); #1;
      m0_write = 0;
      @(negedge clk);
      checks++;
      if (s_write !== 1'b0 || comp !== 1) begin
         errors++;
         $display("FAIL wr_done got=s_write %b completions %0d exp=0 1", s_write, comp);
      end
      $display("write_stall: completions=%0d", comp);
   endtask

   task automatic test_back_to_back();
      int order[4];
      int expo[4];
      int n = 0, rem0 = 2, rem1 = 2;
      bit done0, done1;
`ifdef MIPS_BUS_ARBITER_ROUND_ROBIN_EN
      expo = '{0, 1, 0, 1};
`else
      expo = '{0, 0, 1, 1};
`endif
      order = '{9, 9, 9, 9};
      @(negedge clk) reset = 0;
      @(negedge clk) reset = 1;
      @(posedge clk); #1;
      m0_read = 1; m0_address = 32'h100; m1_read = 1; m1_address = 32'h200; s_waitrequest = 0;
      for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
         done0 = 0; done1 = 0;
         @(negedge clk);
         if (!m0_waitrequest) begin
            order[n] = 0; n++; done0 = 1;
            checks++;
            if (s_address !== 32'h100) begin
               errors++;
               $display("FAIL b2b_addr0 got=%h exp=00000100", s_address);
            end
         end else if (!m1_waitrequest) begin
            order[n] = 1; n++; done1 = 1;
            checks++;
            if (s_address !== 32'h200) begin
               errors++;
               $display("FAIL b2b_addr1 got=%h exp=00000200", s_address);
            end
         end
         @(posedge clk); #1;
         if (done0) begin rem0--; if (rem0 == 0) m0_read = 0; end
         if (done1) begin rem1--; if (rem1 == 0) m1_read = 0; end
      end
      m0_read = 0; m1_read = 0;
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL b2b_timeout got=%0d transfers exp=4", n);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (order[k] !== expo[k]) begin
            errors++;
            $display("FAIL b2b_grant[%0d] got=m%0d exp=m%0d", k, order[k], expo[k]);
         end
      end
      $display("back_to_back: grants m%0d m%0d m%0d m%0d", order[0], order[1], order[2], order[3]);
   endtask

   task automatic test_reset_mid_grant();
      @(posedge clk); #1;
      m1_read = 1; m1_address = 32'hBFC0_0040; s_waitrequest = 1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (s_read !== 1'b1 || m1_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_granted got=%b %b exp=1 1", s_read, m1_waitrequest);
      end
      #2 reset = 0;
      #1;
      checks++;
      if (s_read !== 1'b0 || m1_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_async got=s_read %b wr %b exp=0 1", s_read, m1_waitrequest);
      end
      @(negedge clk) reset = 1;
      #1;
      checks++;
      if (s_read !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_idle got=%b exp=0", s_read);
      end
      @(posedge clk); #1;
      s_waitrequest = 0;
      @(negedge clk);
      checks++;
      if (s_read !== 1'b1 || s_address !== 32'hBFC0_0040 || m1_waitrequest !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_regrant got=%b %h %b exp=1 bfc00040 0", s_read, s_address, m1_waitrequest);
      end
      @(posedge clk); #1;
      m1_read = 0;
      $display("reset_mid_grant: m1 regranted addr=%h", s_address);
   endtask

   task automatic test_collision();
      @(posedge clk); #1;
      m0_read = 1; m0_write = 1; m0_address = 32'h2000; s_waitrequest = 0;
      @(negedge clk);
      checks++;
      if (protocol_error !== 1'b0) begin
         errors++;
         $display("FAIL coll_pre got=%b exp=0", protocol_error);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (s_write !== 1'b1 || s_read !== 1'b0 || s_address !== 32'h2000) begin
         errors++;
         $display("FAIL coll_bus got=rd %b wr %b %h exp=0 1 00002000", s_read, s_write, s_address);
      end
      @(posedge clk); #1;
      m0_read = 0; m0_write = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (protocol_error !== 1'b1 || s_write !== 1'b0) begin
         errors++;
         $display("FAIL coll_sticky got=perr %b s_write %b exp=1 0", protocol_error, s_write);
      end
      reset = 0;
      #1;
      checks++;
      if (protocol_error !== 1'b0) begin
         errors++;
         $display("FAIL coll_clear got=%b exp=0", protocol_error);
      end
      @(negedge clk) reset = 1;
      $display("collision: protocol_error set then cleared by reset");
   endtask

   initial begin
      test_reset();
      test_read_m1();
      test_write_stall();
      test_back_to_back();
      test_reset_mid_grant();
      test_collision();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data bus width in bits; byteenable width is DATA_W/8.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m0_read, m0_write  input  1 each  data-port master strobes.
REQ-006 m0_address  input  ADDR_W;  m0_writedata  input  DATA_W;  m0_byteenable  input  DATA_W/8.
REQ-007 m0_waitrequest  output  1;  m0_readdata  output  DATA_W.
REQ-008 m1_* (instruction-fetch master) SHALL mirror REQ-005..REQ-007 exactly.
REQ-009 s_read, s_write  output  1;  s_address  output  ADDR_W;  s_writedata  output  DATA_W;  s_byteenable  output  DATA_W/8  (shared memory bus).
REQ-010 s_waitrequest  input  1;  s_readdata  input  DATA_W.
REQ-011 protocol_error  output  1  sticky flag, set on master read+write collision.

Function
REQ-012 FSM states SHALL be IDLE, GRANT0, GRANT1, held in a register.
REQ-013 A master SHALL be "requesting" when its read or write is 1; masters hold strobes and operands stable until their waitrequest is 0.
REQ-014 In IDLE, all s_* outputs SHALL be 0 and both m*_waitrequest SHALL be 1.
REQ-015 In IDLE with at least one requester, the next state SHALL be GRANTx for the winner (one-cycle arbitration latency); with none, stay IDLE.
REQ-016 In GRANTx, s_* outputs SHALL combinationally equal master x's strobes and operands, mx_waitrequest SHALL equal s_waitrequest, and the other master's waitrequest SHALL be 1.
REQ-017 m0_readdata and m1_readdata SHALL both equal s_readdata at all times; data is valid only for the granted master when its waitrequest is 0.
REQ-018 In GRANTx, a transfer completes on a rising edge where master x is requesting and s_waitrequest is 0; the next state SHALL be IDLE.
REQ-019 In GRANTx, if master x stops requesting without completing, the next state SHALL be IDLE and no transfer is counted.
REQ-020 If the granted master asserts read and write together, s_write SHALL be 1, s_read SHALL be 0, and protocol_error SHALL be set on that edge and held until reset.
REQ-021 Minimum throughput SHALL be one transfer per 2 cycles (IDLE + GRANT with s_waitrequest=0); each waitrequest-high cycle adds one cycle.
REQ-022 A requester not granted SHALL keep waitrequest=1 indefinitely; requests are never dropped or reordered.

Reset
REQ-023 On reset=0, the state SHALL become IDLE immediately; s_read/s_write SHALL drop asynchronously with it, even mid-transfer.
REQ-024 Reset values: all s_* = 0, m0/m1_waitrequest = 1, protocol_error = 0, last-grant register = 1 (master 0 wins first tie).
REQ-025 The first arbitration SHALL occur on the first rising edge after reset returns to 1.

Configuration
REQ-026 Macro MIPS_BUS_ARBITER_ROUND_ROBIN_EN: when defined, simultaneous requests in IDLE SHALL be granted to the master not granted last; the last-grant register updates on entry to GRANTx.
REQ-027 Without MIPS_BUS_ARBITER_ROUND_ROBIN_EN, master 0 SHALL always win simultaneous requests, and no last-grant register is built.

Verification
REQ-028 Reset release, no requests, 10 cycles -> state IDLE, s_read=s_write=0, both waitrequests=1, protocol_error=0.
REQ-029 m1_read at 0xBFC00000, s_waitrequest=0, s_readdata=0x24020005 -> s_read=1 with s_address=0xBFC00000 on cycle 2; m1_waitrequest=0, m1_readdata=0x24020005 that cycle; IDLE on cycle 3.
REQ-030 m0_write 0x00001000, data 0xDEADBEEF, byteenable 0xF, s_waitrequest high for 3 cycles -> s_write held 4 cycles with stable operands; m0_waitrequest tracks s_waitrequest; one completion.
REQ-031 m0 and m1 request together back-to-back for 4 transfers -> with ROUND_ROBIN_EN grants m0,m1,m0,m1; without it all m0 grants until m0 idles, then m1.
REQ-032 reset=0 asserted during GRANT1 with s_waitrequest=1 -> s_read drops before next clk edge; after release, pending m1 re-granted after one IDLE cycle.
REQ-033 m0 asserts read and write together -> s_write=1, s_read=0, protocol_error=1 and held after the transfer until reset.
